// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-to-WB pipeline bus carrying the memory-stage result into the writeback stage.
//   master : MEM stage, drives every mem_* field
//   slave  : WB stage, samples every mem_* field
interface wb_stage_if;
    logic        mem_valid;
    logic        mem_regwr;
    logic [4:0]  mem_wraddr;
    logic [1:0]  mem_wbsel;
    logic [2:0]  mem_ldtype;
    logic [31:0] mem_aluout;
    logic [31:0] mem_rdata;
    logic [31:0] mem_pc4;
    modport master (output mem_valid, mem_regwr, mem_wraddr, mem_wbsel, mem_ldtype, mem_aluout, mem_rdata, mem_pc4);
    modport slave  (input  mem_valid, mem_regwr, mem_wraddr, mem_wbsel, mem_ldtype, mem_aluout, mem_rdata, mem_pc4);
endinterface

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register plus writeback select driving the register-file write port.
//   clk     : clock, all state updates on posedge
//   reset   : asynchronous active-low reset
//   stall   : hold WB register contents
//   flush   : invalidate incoming instruction (beats stall)
//   mem     : MEM-stage bus (valid, regwr, wraddr, wbsel, ldtype, aluout, rdata, pc4)
//   wr/addr3/data3 : register-file write port, also the ID/EX forwarding source
//   wb_valid: WB register holds a real instruction
//   ld_err  : WB instruction is a misaligned load
//   instret : retired-instruction counter
module wb_stage #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    wb_stage_if.slave            mem,
    output logic                 wr,
    output logic [4:0]           addr3,
    output logic [31:0]          data3,
    output logic                 wb_valid,
    output logic                 ld_err,
    output logic [INSTRET_W-1:0] instret
);
    logic        v;
    logic        regwr;
    logic [4:0]  wraddr;
    logic [1:0]  wbsel;
    logic [2:0]  ldtype;
    logic [31:0] aluout;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [1:0]  off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_val;
    logic        is_half;
    logic        is_byte;
    logic        misaligned;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v       <= 1'b0;
            regwr   <= 1'b0;
            wraddr  <= '0;
            wbsel   <= '0;
            ldtype  <= '0;
            aluout  <= '0;
            rdata   <= '0;
            pc4     <= '0;
            instret <= '0;
        end else begin
            // The instruction sitting in WB retires when it is allowed to leave.
            if (v && !stall && !flush)
                instret <= instret + 1'b1;
            if (flush) begin
                v <= 1'b0;
            end else if (!stall) begin
                v      <= mem.mem_valid;
                regwr  <= mem.mem_regwr;
                wraddr <= mem.mem_wraddr;
                wbsel  <= mem.mem_wbsel;
                ldtype <= mem.mem_ldtype;
                aluout <= mem.mem_aluout;
                rdata  <= mem.mem_rdata;
                pc4    <= mem.mem_pc4;
            end
        end
    end

    // Load extraction from registered fields only, so outputs never see mem_* combinationally.
    always_comb begin
        off        = aluout[1:0];
        byte_sel   = off[1] ? (off[0] ? rdata[31:24] : rdata[23:16])
                            : (off[0] ? rdata[15:8]  : rdata[7:0]);
        half_sel   = off[1] ? rdata[31:16] : rdata[15:0];
        is_byte    = (ldtype == 3'b001) || (ldtype == 3'b010);
        is_half    = (ldtype == 3'b011) || (ldtype == 3'b100);
        ld_val     = (ldtype == 3'b001) ? {{24{byte_sel[7]}}, byte_sel} :
                     (ldtype == 3'b010) ? {24'h0, byte_sel} :
                     (ldtype == 3'b011) ? {{16{half_sel[15]}}, half_sel} :
                     (ldtype == 3'b100) ? {16'h0, half_sel} : rdata;
        // Unknown load types behave as lw, so they need word alignment too.
        misaligned = (wbsel == 2'b01) &&
                     (is_half ? off[0] : (!is_byte && (off != 2'b00)));
        ld_err     = v && misaligned;
        data3      = (wbsel == 2'b01) ? ld_val : (wbsel == 2'b10) ? pc4 : aluout;
        wr         = v && regwr && (wraddr != 5'd0) && !ld_err;
        addr3      = wraddr;
        wb_valid   = v;
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table-driven, hand-sequenced and randomized checks of wb_stage against a behavioural model.
module tb_wb_stage;
    typedef struct {
        logic        v;
        logic        rw;
        logic [4:0]  a;
        logic [1:0]  sel;
        logic [2:0]  lt;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [31:0] pc;
    } ins_t;

    typedef struct {
        ins_t        i;
        logic        ewr;
        logic [31:0] ed;
        logic        eerr;
    } vec_t;

    logic        clk = 0;
    logic        reset = 0;
    logic        stall = 0;
    logic        flush = 0;
    logic        wr;
    logic [4:0]  addr3;
    logic [31:0] data3;
    logic        wb_valid;
    logic        ld_err;
    logic [31:0] instret;

    int n_cmp = 0;
    int n_fail = 0;

    ins_t        mrec;
    logic        mv = 0;
    logic [31:0] m_ir = 0;

    wb_stage_if mif();

    wb_stage #(.INSTRET_W(32)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .mem(mif.slave),
        .wr(wr), .addr3(addr3), .data3(data3), .wb_valid(wb_valid), .ld_err(ld_err), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input ins_t i);
        mif.mem_valid  = i.v;
        mif.mem_regwr  = i.rw;
        mif.mem_wraddr = i.a;
        mif.mem_wbsel  = i.sel;
        mif.mem_ldtype = i.lt;
        mif.mem_aluout = i.alu;
        mif.mem_rdata  = i.rd;
        mif.mem_pc4    = i.pc;
    endtask

    function automatic ins_t mk(logic v, logic rw, int a, int sel, int lt,
                                logic [31:0] alu, logic [31:0] rd, logic [31:0] pc);
        ins_t i;
        i.v = v; i.rw = rw; i.a = 5'(a); i.sel = 2'(sel); i.lt = 3'(lt);
        i.alu = alu; i.rd = rd; i.pc = pc;
        return i;
    endfunction

    // Reference: load value computed arithmetically from the byte offset.
    function automatic logic [31:0] m_load(ins_t i);
        int unsigned off = i.alu % 4;
        logic [31:0] b = (i.rd >> (8 * off)) & 32'hFF;
        logic [31:0] h = (i.rd >> (16 * (off / 2))) & 32'hFFFF;
        case (i.lt)
            3'd1: return (b >= 128) ? (b | 32'hFFFFFF00) : b;
            3'd2: return b;
            3'd3: return (h >= 32768) ? (h | 32'hFFFF0000) : h;
            3'd4: return h;
            default: return i.rd;
        endcase
    endfunction

    function automatic logic m_mis(ins_t i);
        int unsigned off = i.alu % 4;
        if (i.sel != 2'd1) return 1'b0;
        if (i.lt == 3'd3 || i.lt == 3'd4) return (off % 2) == 1;
        if (i.lt == 3'd1 || i.lt == 3'd2) return 1'b0;
        return off != 0;
    endfunction

    function automatic logic [31:0] m_data(ins_t i);
        return (i.sel == 2'd1) ? m_load(i) : (i.sel == 2'd2) ? i.pc : i.alu;
    endfunction

    task automatic tick(input ins_t cur, input logic st, input logic fl);
        drive(cur);
        stall = st;
        flush = fl;
        @(posedge clk);
        if (mv && !st && !fl) m_ir++;
        if (fl) mv = 0;
        else if (!st) begin
            mv = cur.v;
            mrec = cur;
        end
        #1;
    endtask

    task automatic cmp_model(input string tag);
        logic err = mv && m_mis(mrec);
        chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(mv));
        chk({tag, ".ld_err"}, 32'(ld_err), 32'(err));
        chk({tag, ".wr"}, 32'(wr), 32'(mv && mrec.rw && mrec.a != 0 && !err));
        if (mv) begin
            chk({tag, ".addr3"}, 32'(addr3), 32'(mrec.a));
            chk({tag, ".data3"}, data3, m_data(mrec));
        end
        chk({tag, ".instret"}, instret, m_ir);
    endtask

    vec_t tbl[12];
    ins_t idle;
    ins_t hold;

    initial begin
        localparam logic [31:0] RD = 32'h80FF7F01;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
        mrec = idle;
        tbl[0]  = '{mk(1, 1, 5, 0, 0, 32'h12345678, RD, 32'h4), 1, 32'h12345678, 0};
        tbl[1]  = '{mk(1, 1, 6, 1, 1, 32'h2, RD, 32'h8), 1, 32'hFFFFFFFF, 0};
        tbl[2]  = '{mk(1, 1, 7, 1, 2, 32'h3, RD, 32'hC), 1, 32'h00000080, 0};
        tbl[3]  = '{mk(1, 1, 8, 1, 3, 32'h2, RD, 32'h10), 1, 32'hFFFF80FF, 0};
        tbl[4]  = '{mk(1, 1, 9, 1, 4, 32'h0, RD, 32'h14), 1, 32'h00007F01, 0};
        tbl[5]  = '{mk(1, 1, 10, 1, 0, 32'h0, RD, 32'h18), 1, 32'h80FF7F01, 0};
        tbl[6]  = '{mk(1, 1, 11, 1, 3, 32'h1, RD, 32'h1C), 0, 32'h00007F01, 1};
        tbl[7]  = '{mk(1, 1, 31, 2, 0, 32'h55, RD, 32'h00400010), 1, 32'h00400010, 0};
        tbl[8]  = '{mk(1, 1, 0, 0, 0, 32'h0000DEAD, RD, 32'h24), 0, 32'h0000DEAD, 0};
        tbl[9]  = '{mk(0, 1, 7, 0, 0, 32'h77, RD, 32'h28), 0, 32'h77, 0};
        tbl[10] = '{mk(1, 1, 12, 1, 5, 32'h2, RD, 32'h2C), 0, RD, 1};
        tbl[11] = '{mk(1, 1, 13, 0, 0, 32'h3, RD, 32'h30), 1, 32'h3, 0};

        drive(mk(1, 1, 4, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF));
        repeat (2) @(posedge clk);
        #1;
        chk("rst.wr", 32'(wr), 0);
        chk("rst.addr3", 32'(addr3), 0);
        chk("rst.data3", data3, 0);
        chk("rst.wb_valid", 32'(wb_valid), 0);
        chk("rst.ld_err", 32'(ld_err), 0);
        chk("rst.instret", instret, 0);
        @(negedge clk);
        reset = 1;
        drive(idle);

        for (int k = 0; k < 12; k++) begin
            tick(tbl[k].i, 0, 0);
            chk($sformatf("tbl%0d.wr", k), 32'(wr), 32'(tbl[k].ewr));
            chk($sformatf("tbl%0d.addr3", k), 32'(addr3), 32'(tbl[k].i.a));
            chk($sformatf("tbl%0d.data3", k), data3, tbl[k].ed);
            chk($sformatf("tbl%0d.ld_err", k), 32'(ld_err), 32'(tbl[k].eerr));
            chk($sformatf("tbl%0d.wb_valid", k), 32'(wb_valid), 32'(tbl[k].i.v));
            chk($sformatf("tbl%0d.instret", k), instret, m_ir);
        end
        tick(idle, 0, 0);
        chk("tbl.instret_total", instret, 32'd11);

        hold = mk(1, 1, 9, 0, 0, 32'hCAFEF00D, 0, 0);
        tick(hold, 0, 0);
        cmp_model("pre_stall");
        for (int k = 0; k < 3; k++) begin
            tick(mk(1, 1, 3, 2, 0, 32'h1, 32'h2, 32'h3), 1, 0);
            chk($sformatf("stall%0d.wr", k), 32'(wr), 1);
            chk($sformatf("stall%0d.addr3", k), 32'(addr3), 9);
            chk($sformatf("stall%0d.data3", k), data3, 32'hCAFEF00D);
            chk($sformatf("stall%0d.instret", k), instret, m_ir);
        end
        tick(mk(1, 1, 3, 0, 0, 32'h1, 0, 0), 1, 1);
        chk("flush.wb_valid", 32'(wb_valid), 0);
        chk("flush.wr", 32'(wr), 0);
        chk("flush.instret", instret, m_ir);

        for (int k = 0; k < 400; k++) begin
            ins_t r;
            logic st, fl;
            r = mk($urandom_range(0, 9) != 0, $urandom_range(0, 5) != 0,
                   ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31),
                   $urandom_range(0, 3), $urandom_range(0, 7),
                   $urandom, $urandom, $urandom);
            st = $urandom_range(0, 4) == 0;
            fl = $urandom_range(0, 9) == 0;
            tick(r, st, fl);
            cmp_model($sformatf("rnd%0d", k));
        end

        tick(mk(1, 1, 3, 0, 0, 32'h0BADBEEF, 0, 0), 0, 0);
        chk("pre_rst.wr", 32'(wr), 1);
        #2;
        reset = 0;
        #1;
        chk("async_rst.wr", 32'(wr), 0);
        chk("async_rst.data3", data3, 0);
        chk("async_rst.addr3", 32'(addr3), 0);
        chk("async_rst.wb_valid", 32'(wb_valid), 0);
        chk("async_rst.instret", instret, 0);
        @(negedge clk);
        reset = 1;
        mv = 0;
        m_ir = 0;
        mrec = idle;
        tick(mk(1, 1, 2, 0, 0, 32'h1, 0, 0), 0, 0);
        tick(idle, 0, 0);
        cmp_model("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
# wb_stage

MEM/WB pipeline register and writeback stage of the pipelined CPU. Captures the memory-stage result, extracts and extends load data, selects the writeback value, and drives the register file's write port (`wr`, `addr3`, `data3`). The same registered write information is exported for ID/EX forwarding. A 32-bit retired-instruction counter is maintained for test.

## Interface
Parameters:
- `INSTRET_W`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold the WB register contents this cycle.
- `flush`  in  1  invalidate the incoming instruction; takes priority over `stall`.
- `mem_valid`  in  1  MEM stage holds a real instruction.
- `mem_regwr`  in  1  instruction writes a GPR.
- `mem_wraddr`  in  5  destination GPR.
- `mem_wbsel`  in  2  writeback source: 00 ALU, 01 load, 10 PC+4 (link), 11 reserved, treated as ALU.
- `mem_ldtype`  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, others treated as lw.
- `mem_aluout`  in  32  ALU result; bits [1:0] are the load byte offset.
- `mem_rdata`  in  32  raw data-memory word.
- `mem_pc4`  in  32  PC+4 of the instruction.
- `wr`  out  1  register-file write enable.
- `addr3`  out  5  register-file write address.
- `data3`  out  32  register-file write data.
- `wb_valid`  out  1  WB register holds a valid instruction.
- `ld_err`  out  1  current WB instruction is a misaligned load.
- `instret`  out  `INSTRET_W`  retired-instruction count.

## Operation
- The WB register holds v, regwr, wraddr, wbsel, ldtype, aluout, rdata and pc4. Payload is captured raw; extraction is combinational from the registered fields.
- Update on each posedge:
  - If `flush`: v <= 0, payload don't-care.
  - Else if `stall`: all fields hold.
  - Else: capture all `mem_*` fields, with v <= `mem_valid`.
- Load extraction. The byte offset is aluout[1:0], with little-endian lanes (byte k = rdata[8k+7:8k]).
  - lb/lbu: select byte k; sign-extend for lb, zero-extend for lbu.
  - lh/lhu: offset[1] selects the half (0 = rdata[15:0], 1 = rdata[31:16]); sign-extend for lh, zero-extend for lhu.
  - lw: full word.
- Misalignment:
  - lh/lhu with offset[0]=1, or lw with offset != 0, is misaligned, but only when wbsel=01.
  - `ld_err` = v & misaligned.
- `data3` source by wbsel: ALU → aluout; load → extracted value; link → pc4.
- `wr` = v & regwr & (wraddr != 0) & ~ld_err. `addr3` = wraddr.
- Writes to $0 are never requested (`wr`=0), even though the register file also ignores them.
- `instret` increments by 1 at a posedge where v=1 & ~stall & ~flush. It wraps modulo 2^`INSTRET_W`. Misaligned loads still count.

## Timing
- Reset (asynchronous, active-low) clears v, all payload fields and `instret`. During and after reset, the outputs are `wr`=0, `addr3`=0, `data3`=0, `wb_valid`=0, `ld_err`=0 and `instret`=0.
- Reset asserted mid-operation clears state immediately, with no clock required.
- Latency: a MEM-stage instruction captured at posedge N appears on `wr`/`addr3`/`data3` during cycle N..N+1. The register file commits it at posedge N+1.
- Register-file reads are combinational and see old data until posedge N+1. The ID stage must therefore forward from `addr3`/`data3` when `wr` is set and the addresses match; this block guarantees these signals are stable for the whole cycle.
- While stalled, `wr` stays asserted with the same address and data. This causes repeated idempotent writes, and `instret` does not advance.
- `flush` together with `stall`: flush wins, v=0 next cycle, and `wr`=0.
- All outputs are glitch-free functions of registered state only; there is no combinational path from `mem_*` inputs to outputs.

## Test plan
- Reset low mid-stream with v=1, `wr`=1 → `wr`=0, `data3`=0 and `instret`=0 immediately, without a clock edge.
- ALU writeback: mem_valid=1, regwr=1, wraddr=5, wbsel=00, aluout=0x12345678 → next cycle `wr`=1, `addr3`=5, `data3`=0x12345678, `instret`+1.
- Loads with rdata=0x80FF7F01:
  - lb, offset 2 → 0xFFFFFFFF.
  - lbu, offset 3 → 0x00000080.
  - lh, offset 2 → 0xFFFF80FF.
  - lhu, offset 0 → 0x00007F01.
  - lw, offset 0 → 0x80FF7F01.
- Misaligned lh at offset 1 → `ld_err`=1 and `wr`=0 for that cycle; `instret` still increments.
- Link to $31 with pc4=0x00400010 → `data3`=0x00400010 and `addr3`=31. A write to $0 (wraddr=0, regwr=1) → `wr`=0.
- `stall`=1 for 3 cycles → outputs held, `wr` stays asserted, `instret` unchanged. Then `flush`=1 together with `stall`=1 → `wb_valid`=0 and `wr`=0 next cycle.
